stop_it_ctrl: RTL and testbench

//  Game sequencer for the Stop-It LED bar. Drives the shift/load/off controls of the
//  16-LED shifter: paces fill steps from a cycle divider and gates switch loads.

---
 rtl/stop_it_ctrl.sv | 147 ++++++++++++++
 tb/tb_stop_it_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_it_ctrl.sv
// Stop-It game sequencer: paces LED fill shifts, gates switch loads, judges the stop press and flashes the result.
// Optional feature macro SPEEDUP_EN: a saturating win level shortens the RUN tick period.
module stop_it_ctrl #(
  parameter int TICK_DIV  = 4,
  parameter int FLASH_CNT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        load_req_i,
  input  logic [3:0]  target_i,
  input  logic [15:0] leds_i,
  output logic        shift_o,
  output logic        load_o,
  output logic        off_o,
  output logic        win_o,
  output logic        lose_o,
  output logic [2:0]  state_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int FW = $clog2(2 * FLASH_CNT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WIN  = 3'd2,
    S_LOSE = 3'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [FW-1:0]   r_flash, w_flash_nxt;
  logic            r_shift, w_shift_nxt;
  logic            r_load, w_load_nxt;
  logic            r_off, w_off_nxt;
  logic            r_win, w_win_nxt;
  logic            r_lose, w_lose_nxt;
  logic [CW-1:0]   w_last;
  logic            w_exp;
  logic [3:0]      w_tgt_up;
  logic            w_won;

`ifdef SPEEDUP_EN
  logic [1:0]      r_level, w_level_nxt;
  // flashing keeps the base pace; only RUN speeds up with the level
  assign w_last = (r_state == S_RUN) ? CW'((TICK_DIV >> r_level) - 1) : CW'(TICK_DIV - 1);
`else
  assign w_last = CW'(TICK_DIV - 1);
`endif

  assign w_exp    = (r_cnt == w_last);
  assign w_tgt_up = target_i + 4'd1;
  // win: target lit and it is the leading edge of the filled run
  assign w_won    = stop_i & leds_i[target_i] & ((target_i == 4'd15) | ~leds_i[w_tgt_up]);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_exp ? '0 : r_cnt + CW'(1);
    w_flash_nxt = r_flash;
    w_shift_nxt = 1'b0;
    w_load_nxt  = 1'b0;
    w_off_nxt   = r_off;
    w_win_nxt   = r_win;
    w_lose_nxt  = r_lose;
`ifdef SPEEDUP_EN
    w_level_nxt = r_level;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_win_nxt   = 1'b0;
          w_lose_nxt  = 1'b0;
        end else if (load_req_i) begin
          w_load_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (stop_i || (w_exp && leds_i == 16'hFFFF)) begin
          w_state_nxt = w_won ? S_WIN : S_LOSE;
          w_cnt_nxt   = '0;
          w_flash_nxt = '0;
          w_off_nxt   = 1'b1;
          w_win_nxt   = w_won;
          w_lose_nxt  = ~w_won;
`ifdef SPEEDUP_EN
          w_level_nxt = w_won ? ((r_level == 2'd3) ? 2'd3 : r_level + 2'd1) : 2'd0;
`endif
        end else if (w_exp) begin
          w_shift_nxt = 1'b1;
        end
      end
      S_WIN, S_LOSE: begin
        if (w_exp) begin
          if (r_flash == FW'(2 * FLASH_CNT - 1)) begin
            w_state_nxt = S_IDLE;
            w_flash_nxt = '0;
            w_off_nxt   = 1'b0;
          end else begin
            w_flash_nxt = r_flash + FW'(1);
            w_off_nxt   = ~r_off;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_flash <= '0;
      r_shift <= 1'b0;
      r_load  <= 1'b0;
      r_off   <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
`ifdef SPEEDUP_EN
      r_level <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flash <= w_flash_nxt;
      r_shift <= w_shift_nxt;
      r_load  <= w_load_nxt;
      r_off   <= w_off_nxt;
      r_win   <= w_win_nxt;
      r_lose  <= w_lose_nxt;
`ifdef SPEEDUP_EN
      r_level <= w_level_nxt;
`endif
    end
  end

  assign shift_o = r_shift;
  assign load_o  = r_load;
  assign off_o   = r_off;
  assign win_o   = r_win;
  assign lose_o  = r_lose;
  assign state_o = r_state;

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Bench for stop_it_ctrl: a shifter stand-in feeds leds_i back, an arithmetic game model is checked every cycle.
`timescale 1ns/1ps
module tb_stop_it_ctrl;
  localparam int TD = 4;
  localparam int FC = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        load_req_i = 1'b0;
  logic [3:0]  target_i = 4'd0;
  logic [15:0] leds_i;
  logic [15:0] sw = 16'h0;
  logic        shift_o, load_o, off_o, win_o, lose_o;
  logic [2:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  stop_it_ctrl #(.TICK_DIV(TD), .FLASH_CNT(FC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .load_req_i(load_req_i), .target_i(target_i), .leds_i(leds_i),
    .shift_o(shift_o), .load_o(load_o), .off_o(off_o), .win_o(win_o),
    .lose_o(lose_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // LED shifter stand-in: load takes the switches, shift fills a 1 in from the bottom
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      leds_i <= 16'h0;
    else if (load_o)  leds_i <= sw;
    else if (shift_o) leds_i <= {leds_i[14:0], 1'b1};
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Game model: time in a state is counted from entry; tick expiries and flash phases fall out by division.
  int   m_state = 0, m_since = 0, m_level = 0, m_p = TD, m_t = 0;
  logic m_shift = 0, m_load = 0, m_off = 0, m_win = 0, m_lose = 0, m_won = 0, m_above = 0;

  task automatic m_enter_result(input logic won);
    m_state = won ? 2 : 3;
    m_since = 0;
    m_off   = 1'b1;
    m_win   = won;
    m_lose  = !won;
`ifdef SPEEDUP_EN
    m_level = won ? ((m_level < 3) ? m_level + 1 : 3) : 0;
`endif
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_state = 0; m_since = 0; m_level = 0;
      m_shift = 0; m_load = 0; m_off = 0; m_win = 0; m_lose = 0;
      chk("model_reset", {state_o, shift_o, load_o, off_o, win_o, lose_o}, 8'h00);
    end else begin
      chk("model_cycle", {state_o, shift_o, load_o, off_o, win_o, lose_o},
          {3'(m_state), m_shift, m_load, m_off, m_win, m_lose});
      m_shift = 1'b0;
      m_load  = 1'b0;
      case (m_state)
        0: begin
          if (start_i) begin
            m_state = 1; m_since = 0; m_win = 0; m_lose = 0;
          end else if (load_req_i) begin
            m_load = 1'b1;
          end
        end
        1: begin
          m_p = TD >> m_level;
          m_t = int'(target_i);
          m_above = (m_t == 15) ? 1'b0 : leds_i[m_t + 1];
          if (stop_i) begin
            m_won = leds_i[m_t] && !m_above;
            m_enter_result(m_won);
          end else if ((m_since % m_p) == m_p - 1) begin
            if (leds_i == 16'hFFFF) m_enter_result(1'b0);
            else begin
              m_shift = 1'b1;
              m_since++;
            end
          end else begin
            m_since++;
          end
        end
        default: begin
          m_since++;
          if (m_since == 2 * FC * TD) begin
            m_state = 0; m_off = 0;
          end else begin
            m_off = ((m_since / TD) % 2) == 0;
          end
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    sw = v;
    load_req_i = 1'b1;
    cyc();
    load_req_i = 1'b0;
    cyc();
  endtask

  task automatic begin_round();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (state_o != 3'd0 && i < 100) begin
      cyc();
      i++;
    end
    chk(name, 32'(state_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", {shift_o, load_o, off_o, win_o, lose_o}, 5'b0);
    rst_ni = 1'b1;
    repeat (5) cyc();
    chk("idle_state", 32'(state_o), 32'd0);
    chk("idle_outs", {shift_o, load_o, off_o, win_o, lose_o}, 5'b0);

    sw = 16'h0;
    load_req_i = 1'b1;
    cyc();
    load_req_i = 1'b0;
    chk("load_next_cycle", 32'(load_o), 32'd1);
    cyc();
    chk("load_one_cycle", 32'(load_o), 32'd0);

    start_i = 1'b1;
    load_req_i = 1'b1;
    cyc();
    start_i = 1'b0;
    load_req_i = 1'b0;
    chk("start_run", 32'(state_o), 32'd1);
    chk("start_beats_load", 32'(load_o), 32'd0);
    for (int k = 1; k <= 13; k++) begin
      load_req_i = (k == 2);
      cyc();
      load_req_i = 1'b0;
      chk("run_shift_pace", 32'(shift_o), 32'((k % 4) == 0));
      chk("run_no_load", 32'(load_o), 32'd0);
    end
    chk("fill_0x7", 32'(leds_i), 32'h0007);

    target_i = 4'd2;
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk("win_state", 32'(state_o), 32'd2);
    chk("win_flags", {win_o, lose_o, off_o}, 3'b101);
    for (int k = 15; k <= 30; k++) begin
      cyc();
      if (k < 30) chk("win_flash_off", 32'(off_o), 32'((((k - 14) / 4) % 2) == 0));
    end
    chk("win_back_idle", 32'(state_o), 32'd0);
    chk("win_idle_flags", {off_o, win_o}, 2'b01);

    do_load(16'h000F);
    target_i = 4'd2;
    begin_round();
    chk("start_clears_win", 32'(win_o), 32'd0);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk("lose_state", 32'(state_o), 32'd3);
    chk("lose_flags", {win_o, lose_o}, 2'b01);
    wait_idle("lose_done");

    do_load(16'hFFFF);
    begin_round();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("overrun_no_shift", 32'(shift_o), 32'd0);
    end
    chk("overrun_lose", {state_o, lose_o}, 4'b0111);
    wait_idle("overrun_done");

    do_load(16'h0003);
    target_i = 4'd1;
    begin_round();
    repeat (3) cyc();
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk("stop_on_expiry_no_shift", 32'(shift_o), 32'd0);
    chk("stop_on_expiry_preshift_win", 32'(state_o), 32'd2);
    wait_idle("expiry_stop_done");

    do_load(16'h0000);
    begin_round();
    repeat (2) cyc();
`ifdef SPEEDUP_EN
    chk("pace_edge2", 32'(shift_o), 32'd1);
`else
    chk("pace_edge2", 32'(shift_o), 32'd0);
`endif
    repeat (2) cyc();
    chk("pace_edge4", 32'(shift_o), 32'd1);
    cyc();
    rst_ni = 1'b0;
    #2;
    chk("midround_reset", {state_o, shift_o, load_o, off_o, win_o, lose_o}, 8'h00);
    repeat (2) cyc();
    rst_ni = 1'b1;
    repeat (4) cyc();
    chk("after_reset_idle", {state_o, shift_o, load_o}, 5'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
